mult_share_arbiter: RTL
=======================

# mult_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 8x8 array multiplier among N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the winning operands onto the multiplier inputs, waits a fixed settle time, then captures the product and returns it tagged with the requester index. It sits between the client logic and a single multiplier instance (x, y -> p), which is driven through the mul_* ports.

## Interface
- WIDTH, 8: operand width; the product is 2*WIDTH bits.
- N_REQ, 4: number of requesters (2..8).
- IDW, 2: requester-index width; must satisfy 2^IDW >= N_REQ.
- CALC_CYCLES, 1: cycles allowed for the multiplier to settle (1..15).

- clk  in  1  rising-edge clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_x  in  N_REQ*WIDTH  flattened multiplicands; requester i uses bits [i*WIDTH +: WIDTH].
- req_y  in  N_REQ*WIDTH  flattened multipliers, same packing.
- req_ready  out  N_REQ  one-hot grant/accept, combinational.
- mul_x  out  WIDTH  registered operand to the multiplier x input.
- mul_y  out  WIDTH  registered operand to the multiplier y input.
- mul_p  in  2*WIDTH  product from the multiplier p output.
- resp_valid  out  1  result valid.
- resp_p  out  2*WIDTH  registered product.
- resp_id  out  IDW  index of the requester that owns resp_p.
- resp_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state is not IDLE.

## Operation
- The FSM has three states: IDLE, CALC and RESP. Reset enters IDLE.
- **IDLE:**
  - If any req_valid bit is high, the grant goes to the first asserted bit, scanning upward from rr_ptr with wrap-around.
  - req_ready[g] = 1 for that cycle only. The transfer completes in that same cycle.
  - On the transfer: mul_x and mul_y load that requester's operands, resp_id is set to g, rr_ptr becomes (g+1) mod N_REQ, cnt is set to CALC_CYCLES-1, and the FSM moves to CALC.
  - If no req_valid bit is high, nothing changes.
- **CALC:**
  - mul_x and mul_y are held stable.
  - When cnt == 0: resp_p is loaded from mul_p, resp_valid is set to 1, and the FSM moves to RESP.
  - Otherwise cnt decrements.
- **RESP:**
  - resp_valid, resp_p and resp_id are held stable until resp_valid && resp_ready.
  - On acceptance: resp_valid is cleared and the FSM moves to IDLE.
  - No grant is issued in the acceptance cycle.
- req_ready is all zeros in CALC and RESP. Requesters hold req_valid and their operands until granted. A requester that drops valid before its grant is simply skipped.
- Arithmetic is unsigned and the block does no arithmetic itself. resp_p is exactly the 2*WIDTH-bit mul_p value, with no truncation.
- Reset values: mul_x = 0, mul_y = 0, resp_p = 0, resp_id = 0, resp_valid = 0, busy = 0, req_ready = 0, rr_ptr = 0, cnt = 0.
- Asserting rst_n low in any state aborts the operation immediately. The in-flight result is discarded and never presented.

## Timing
- A grant in cycle T (req_ready high) gives resp_valid high from cycle T+1+CALC_CYCLES.
- With resp_ready tied high, the earliest next grant is cycle T+2+CALC_CYCLES. Throughput is 1 operation per CALC_CYCLES+2 cycles.
- mul_x and mul_y change only on the IDLE grant edge. The multiplier therefore sees at least CALC_CYCLES full cycles of stable inputs before capture, so the multiplier may be constrained as a CALC_CYCLES multicycle path.
- req_ready depends combinationally on req_valid, state and rr_ptr only. It has no combinational path from resp_ready.
- Simultaneous requests: exactly one grant per IDLE visit. After requester k is served, k has the lowest priority on the next scan.
- If resp_ready is already high in the cycle resp_valid first rises, the result is accepted in that cycle.

## Test plan
- **Single requester:**
  - Stimulus: requester 0 sends x=255, y=255 with CALC_CYCLES=1.
  - Required: req_ready[0] pulses in cycle T; resp_valid rises at T+2 with resp_p=65025 (0xFE01) and resp_id=0; busy is high from T+1 until acceptance.
- **Round-robin order:**
  - Stimulus: requesters 0-3 are all valid from reset with (5,3), (4,2), (2,2), (6,8).
  - Required: grants occur in order 0,1,2,3; results are 15, 8, 4, 48 with matching resp_id; no requester is granted twice.
- **Pointer fairness:**
  - Stimulus: requester 2 alone sends (7,9); then all four requesters assert.
  - Required: the first result is 63 with id 2; the subsequent grant order is 3,0,1,2.
- **Backpressure:**
  - Stimulus: resp_ready is held low for 5 cycles after resp_valid rises, while requester 1 waits with (16,16).
  - Required: resp_p and resp_id stay stable and req_ready stays all zeros throughout; requester 1 is granted in the first IDLE cycle after acceptance and its result is 256.
- **Reset mid-operation:**
  - Stimulus: rst_n is asserted low during CALC of (255,2).
  - Required: all outputs immediately take their reset values; no response with 510 ever appears; after release the arbiter restarts with rr_ptr=0.
- **Settle parameter:**
  - Stimulus: CALC_CYCLES=3 with (12,12).
  - Required: resp_valid rises at T+4 with resp_p=144; mul_x=12 and mul_y=12 are held stable through T+3.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational multiplier
// among N_REQ requesters, returning each product tagged with its requester id.
module mult_share_arbiter #(
    parameter int WIDTH       = 8,
    parameter int N_REQ       = 4,
    parameter int IDW         = 2,
    parameter int CALC_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    input  logic [N_REQ*WIDTH-1:0] req_y,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       mul_x,
    output logic [WIDTH-1:0]       mul_y,
    input  logic [2*WIDTH-1:0]     mul_p,
    output logic                   resp_valid,
    output logic [2*WIDTH-1:0]     resp_p,
    output logic [IDW-1:0]         resp_id,
    input  logic                   resp_ready,
    output logic                   busy
);
    // state   | meaning
    // IDLE    | waiting for a request; grants one requester and loads operands
    // CALC    | operands held on the multiplier while cnt counts down to zero
    // RESP    | product presented until resp_ready accepts it

    localparam int CNTW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     mul_x_q, mul_x_d;
    logic [WIDTH-1:0]     mul_y_q, mul_y_d;
    logic [2*WIDTH-1:0]   resp_p_q, resp_p_d;
    logic [IDW-1:0]       resp_id_q, resp_id_d;
    logic                 resp_valid_q, resp_valid_d;

    logic                 gnt_any;
    logic [IDW-1:0]       gnt_id;
    logic [WIDTH-1:0]     gnt_x;
    logic [WIDTH-1:0]     gnt_y;
    logic [N_REQ-1:0]     gnt_vec;
    int                   best_rank;
    int                   rank;

    // Each requester's rank is its distance above rr_ptr; the lowest valid rank wins.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = '0;
        gnt_x     = '0;
        gnt_y     = '0;
        gnt_vec   = '0;
        best_rank = N_REQ;
        rank      = 0;
        for (int j = 0; j < N_REQ; j++) begin
            rank = j - int'(rr_ptr_q);
            if (rank < 0) begin
                rank = rank + N_REQ;
            end
            if (req_valid[j] && (rank < best_rank)) begin
                best_rank = rank;
                gnt_any   = 1'b1;
                gnt_id    = IDW'(j);
                gnt_x     = req_x[j*WIDTH +: WIDTH];
                gnt_y     = req_y[j*WIDTH +: WIDTH];
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            gnt_vec[j] = gnt_any && (gnt_id == IDW'(j));
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        mul_x_d      = mul_x_q;
        mul_y_d      = mul_y_q;
        resp_p_d     = resp_p_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        req_ready    = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt_vec;
                    mul_x_d   = gnt_x;
                    mul_y_d   = gnt_y;
                    resp_id_d = gnt_id;
                    rr_ptr_d  = (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
                    cnt_d     = CNTW'(CALC_CYCLES-1);
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == '0) begin
                    resp_p_d     = mul_p;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // No transfer can complete while the block is held in reset.
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            mul_x_q      <= '0;
            mul_y_q      <= '0;
            resp_p_q     <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            mul_x_q      <= mul_x_d;
            mul_y_q      <= mul_y_d;
            resp_p_q     <= resp_p_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign mul_x      = mul_x_q;
    assign mul_y      = mul_y_q;
    assign resp_p     = resp_p_q;
    assign resp_id    = resp_id_q;
    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
